// File: rtl/bcd_to_binary.sv
// Packed-BCD to unsigned binary converter using reverse double-dabble (shift right, subtract 3).
// Start/data-valid handshake; flags non-decimal nibbles and results that overflow OUTPUT_WIDTH.
module bcd_to_binary #(
    parameter int DECIMAL_DIGITS = 4,
    parameter int OUTPUT_WIDTH   = 16
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic                        i_Start,
    input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
    output logic [OUTPUT_WIDTH-1:0]     o_Binary,
    output logic                        o_DV,
    output logic                        o_Error,
    output logic                        o_Busy
);

    localparam int BCD_W = DECIMAL_DIGITS * 4;
    localparam int CAT_W = BCD_W + OUTPUT_WIDTH;
    localparam int IDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;

    localparam logic [7:0]       LAST_SHIFT = 8'(OUTPUT_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(DECIMAL_DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK_SHIFT_INDEX,
        SUB,
        CHECK_DIGIT_INDEX,
        DONE
    } state_t;

    state_t                  r_State;
    logic [BCD_W-1:0]        r_BCD;
    logic [OUTPUT_WIDTH-1:0] r_Binary;
    logic [7:0]              r_Loop_Count;
    logic [IDX_W-1:0]        r_Digit_Index;
    logic                    r_Error;
    logic                    r_DV;

    logic                    w_Invalid;
    logic [3:0]              w_Digit;
    logic [CAT_W-1:0]        w_Shifted;

    // NOTE: combinational outputs get a default before any conditional update so no latch is inferred.
    always_comb begin
        w_Invalid = 1'b0;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (i_BCD[i*4 +: 4] > 4'd9) begin
                w_Invalid = 1'b1;
            end
        end
    end

    assign w_Digit   = r_BCD[r_Digit_Index*4 +: 4];
    assign w_Shifted = {r_BCD, r_Binary} >> 1;

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State       <= IDLE;
            r_BCD         <= '0;
            r_Binary      <= '0;
            r_Loop_Count  <= '0;
            r_Digit_Index <= '0;
            r_Error       <= 1'b0;
            r_DV          <= 1'b0;
        end else begin
            case (r_State)
                IDLE: begin
                    r_DV <= 1'b0;
                    if (i_Start) begin
                        r_Binary <= '0;
                        if (w_Invalid) begin
                            r_Error <= 1'b1;
                            r_State <= DONE;
                        end else begin
                            r_BCD         <= i_BCD;
                            r_Error       <= 1'b0;
                            r_Loop_Count  <= '0;
                            r_Digit_Index <= '0;
                            r_State       <= SHIFT;
                        end
                    end
                end

                // LSB of the BCD field moves into the binary MSB; a zero enters the BCD MSB.
                SHIFT: begin
                    r_BCD    <= w_Shifted[CAT_W-1:OUTPUT_WIDTH];
                    r_Binary <= w_Shifted[OUTPUT_WIDTH-1:0];
                    r_State  <= CHECK_SHIFT_INDEX;
                end

                CHECK_SHIFT_INDEX: begin
                    if (r_Loop_Count == LAST_SHIFT) begin
                        r_Loop_Count <= '0;
                        // Anything left in the BCD field is weight >= 2^OUTPUT_WIDTH.
                        if (r_BCD != '0) begin
                            r_Error <= 1'b1;
                        end
                        r_State <= DONE;
                    end else begin
                        r_Loop_Count <= r_Loop_Count + 8'd1;
                        r_State      <= SUB;
                    end
                end

                SUB: begin
                    if (w_Digit >= 4'd8) begin
                        r_BCD[r_Digit_Index*4 +: 4] <= w_Digit - 4'd3;
                    end
                    r_State <= CHECK_DIGIT_INDEX;
                end

                CHECK_DIGIT_INDEX: begin
                    if (r_Digit_Index == LAST_DIGIT) begin
                        r_Digit_Index <= '0;
                        r_State       <= SHIFT;
                    end else begin
                        r_Digit_Index <= r_Digit_Index + 1'b1;
                        r_State       <= SUB;
                    end
                end

                DONE: begin
                    r_DV    <= 1'b1;
                    r_State <= IDLE;
                end

                default: begin
                    r_State <= IDLE;
                end
            endcase
        end
    end

    assign o_Binary = r_Binary;
    assign o_DV     = r_DV;
    assign o_Error  = r_Error;
    assign o_Busy   = (r_State != IDLE);

endmodule

// File: tb/tb_bcd_to_binary.sv
// Bench for bcd_to_binary: a 4-digit/16-bit instance and a 3-digit/8-bit instance,
// with expected results queued at each accepted start and compared when o_DV fires.
module tb_bcd_to_binary;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [15:0] bcd_a;
    logic [11:0] bcd_b;
    logic [15:0] bin_a;
    logic [7:0]  bin_b;
    logic        dv_a, err_a, busy_a;
    logic        dv_b, err_b, busy_b;

    typedef struct {
        logic [15:0] bin;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_to_binary #(.DECIMAL_DIGITS(4), .OUTPUT_WIDTH(16)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Start(start_a), .i_BCD(bcd_a),
        .o_Binary(bin_a), .o_DV(dv_a), .o_Error(err_a), .o_Busy(busy_a)
    );

    bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(8)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_Start(start_b), .i_BCD(bcd_b),
        .o_Binary(bin_b), .o_DV(dv_b), .o_Error(err_b), .o_Busy(busy_b)
    );

    // Reference model: decimal value of the digits, truncated to the output width.
    function automatic exp_t model(input bit sel, input logic [15:0] bcd, input int acc);
        exp_t        e;
        int          digits = sel ? 3 : 4;
        int          width  = sel ? 8 : 16;
        longint      v      = 0;
        bit          bad    = 1'b0;
        logic [3:0]  d;
        for (int i = digits - 1; i >= 0; i--) begin
            d = bcd[i*4 +: 4];
            if (d > 4'd9) bad = 1'b1;
            v = v * 10 + longint'(d);
        end
        e.acc = acc;
        if (bad) begin
            e.bin = '0;
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            e.bin = 16'(v % (longint'(1) << width));
            e.err = (v >= (longint'(1) << width));
            e.lat = (width - 1) * (2 + 2 * digits) + 3;
        end
        return e;
    endfunction

    // Called at a falling edge; the start is accepted on the next rising edge.
    task automatic issue(input bit sel, input logic [15:0] bcd);
        exp_t e = model(sel, bcd, cyc + 1);
        if (sel) begin
            bcd_b   = bcd[11:0];
            start_b = 1'b1;
            q_b.push_back(e);
        end else begin
            bcd_a   = bcd;
            start_a = 1'b1;
            q_a.push_back(e);
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        checks++;
        if ((sel ? dv_b : dv_a) !== 1'b0) begin
            errors++;
            $display("FAIL dv_after_start[%0d]: got %b want 0", sel, sel ? dv_b : dv_a);
        end
    endtask

    // Waits (bounded) for o_DV, pops the oldest expectation and compares; returns in the o_DV cycle.
    task automatic collect(input bit sel, input string name);
        exp_t        e;
        bit          seen    = 1'b0;
        bit          busy_ok = 1'b1;
        logic [15:0] got;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if ((sel ? dv_b : dv_a) === 1'b1) seen = 1'b1;
            else if ((sel ? busy_b : busy_a) !== 1'b1) busy_ok = 1'b0;
        end
        checks++;
        if ((sel ? q_b.size() : q_a.size()) == 0) begin
            errors++;
            $display("FAIL %s: no expectation queued", name);
            return;
        end
        e = sel ? q_b.pop_front() : q_a.pop_front();
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no dv within 400 cycles, want latency %0d", name, e.lat);
            return;
        end
        got = sel ? {8'h00, bin_b} : bin_a;
        if (got !== e.bin) begin
            errors++;
            $display("FAIL %s binary: got %h want %h", name, got, e.bin);
        end
        checks++;
        if ((sel ? err_b : err_a) !== e.err) begin
            errors++;
            $display("FAIL %s error: got %b want %b", name, sel ? err_b : err_a, e.err);
        end
        checks++;
        if (cyc - e.acc !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc - e.acc, e.lat);
        end
        checks++;
        if (!busy_ok || (sel ? busy_b : busy_a) !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: held=%b at_dv=%b want 1/0", name, busy_ok, sel ? busy_b : busy_a);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start_a = 1'b1;
        bcd_a   = 16'h1234;
        start_b = 1'b1;
        bcd_b   = 12'h255;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        checks++;
        if ({bin_a, dv_a, err_a, busy_a} !== 19'h0) begin
            errors++;
            $display("FAIL reset_a: got bin=%h dv=%b err=%b busy=%b want all 0", bin_a, dv_a, err_a, busy_a);
        end
        checks++;
        if ({bin_b, dv_b, err_b, busy_b} !== 11'h0) begin
            errors++;
            $display("FAIL reset_b: got bin=%h dv=%b err=%b busy=%b want all 0", bin_b, dv_b, err_b, busy_b);
        end
    endtask

    task automatic test_basic();
        issue(1'b0, 16'h1234);
        collect(1'b0, "basic_1234");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(1'b0, 16'h9999);
        collect(1'b0, "b2b_9999");
        issue(1'b0, 16'h0000);
        collect(1'b0, "b2b_0000");
    endtask

    task automatic test_invalid_digit();
        @(negedge clk);
        issue(1'b0, 16'h12A4);
        collect(1'b0, "invalid_12A4");
        repeat (3) @(negedge clk);
        checks++;
        if (err_a !== 1'b1 || dv_a !== 1'b0 || bin_a !== 16'h0) begin
            errors++;
            $display("FAIL invalid_hold: got err=%b dv=%b bin=%h want 1/0/0000", err_a, dv_a, bin_a);
        end
        issue(1'b0, 16'h0042);
        collect(1'b0, "after_invalid_0042");
    endtask

    task automatic test_narrow();
        @(negedge clk);
        issue(1'b1, 16'h0300);
        collect(1'b1, "narrow_300_overflow");
        issue(1'b1, 16'h0255);
        collect(1'b1, "narrow_255");
        @(negedge clk);
        issue(1'b1, 16'h03F0);
        collect(1'b1, "narrow_invalid_3F0");
    endtask

    task automatic test_ignored_start();
        @(negedge clk);
        issue(1'b0, 16'h0500);
        repeat (18) @(negedge clk);
        bcd_a   = 16'h0007;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        bcd_a   = 16'hFFFF;
        collect(1'b0, "ignored_start_0500");
        repeat (5) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || dv_a !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_not_queued: got busy=%b dv=%b want 0/0", busy_a, dv_a);
        end
    endtask

    task automatic test_reset_abort();
        bit dv_seen = 1'b0;
        @(negedge clk);
        issue(1'b0, 16'h8765);
        repeat (48) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q_a.delete();
        checks++;
        if (busy_a !== 1'b0 || dv_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got busy=%b dv=%b want 0/0", busy_a, dv_a);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dv_a !== 1'b0 || busy_a !== 1'b0) dv_seen = 1'b1;
        end
        checks++;
        if (dv_seen) begin
            errors++;
            $display("FAIL abort_quiet: got activity after reset want none");
        end
        issue(1'b0, 16'h8765);
        collect(1'b0, "after_abort_8765");
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
            @(negedge clk);
            issue(1'b0, v);
            collect(1'b0, "random_a");
            v[15:12] = 4'h0;
            issue(1'b1, v);
            collect(1'b1, "random_b");
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        bcd_a   = '0;
        bcd_b   = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_invalid_digit();
        test_narrow();
        test_ignored_start();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 50000 cycles");
        $fatal(1);
    end

endmodule
